// File: rtl/fifo_ram_ctrl.sv
// rtl/fifo_ram_ctrl.sv - valid/ready FWFT controller around a registered FIFO RAM
// Optional FIFO_RAM_CTRL_FLUSH_EN adds a synchronous flush input.
module fifo_ram_ctrl #(
    parameter int SIZE   = 512,
    parameter int WIDTH  = 64,
    parameter int AFULL  = SIZE - 8,
    parameter int SBITS1 = $clog2(SIZE) - 1
) (
    input  logic                clk,
    input  logic                reset,
`ifdef FIFO_RAM_CTRL_FLUSH_EN
    input  logic                flush,
`endif
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [WIDTH-1:0]    in_data,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [WIDTH-1:0]    out_data,
    output logic [SBITS1+2:0]   level,
    output logic                almost_full,
    output logic                ram_wen,
    output logic [SBITS1:0]     ram_waddr,
    output logic [WIDTH-1:0]    ram_wdata,
    output logic                ram_ren,
    output logic [SBITS1:0]     ram_raddr,
    input  logic [WIDTH-1:0]    ram_rdata
);

    localparam int AW = SBITS1 + 1;
    localparam int CW = SBITS1 + 2;
    localparam int LW = SBITS1 + 3;
    localparam logic [CW-1:0] FULL_CNT = CW'(SIZE);
    localparam logic [LW-1:0] AFULL_LVL = LW'(AFULL);

    logic [AW-1:0]    wptr;
    logic [AW-1:0]    rptr;
    logic [CW-1:0]    ram_cnt;
    logic             inflight;
    logic [1:0]       stage_cnt;
    logic [WIDTH-1:0] head;
    logic [WIDTH-1:0] skid;

    logic             clr;
    logic             push;
    logic             pop;
    logic [2:0]       occ;
    logic [1:0]       stage_after_pop;

    always_comb begin
`ifdef FIFO_RAM_CTRL_FLUSH_EN
        clr = flush;
`else
        clr = 1'b0;
`endif
        in_ready  = !clr && (ram_cnt != FULL_CNT);
        push      = in_valid && in_ready;
        out_valid = (stage_cnt != 2'd0);
        pop       = out_valid && out_ready;
        // Reads already issued plus words held must never exceed the two stage slots.
        occ       = {1'b0, stage_cnt} + {2'b00, inflight};
        ram_ren   = !clr && (ram_cnt != '0) &&
                    ((occ < 3'd2) || ((occ == 3'd2) && pop));
        stage_after_pop = stage_cnt - {1'b0, pop};

        ram_wen     = push;
        ram_waddr   = wptr;
        ram_wdata   = in_data;
        ram_raddr   = rptr;
        out_data    = head;
        level       = LW'(ram_cnt) + LW'(inflight) + LW'(stage_cnt);
        almost_full = (level >= AFULL_LVL);
    end

    always_ff @(posedge clk) begin
        if (reset || clr) begin
            wptr      <= '0;
            rptr      <= '0;
            ram_cnt   <= '0;
            inflight  <= 1'b0;
            stage_cnt <= 2'd0;
        end else begin
            if (push) begin
                wptr <= wptr + 1'b1;
            end
            if (ram_ren) begin
                rptr <= rptr + 1'b1;
            end
            ram_cnt   <= ram_cnt + CW'(push) - CW'(ram_ren);
            inflight  <= ram_ren;
            stage_cnt <= stage_after_pop + {1'b0, inflight};
        end
    end

    // Returning word lands in head when the stage drains this cycle, otherwise in skid.
    always_ff @(posedge clk) begin
        if (inflight && (stage_after_pop == 2'd0)) begin
            head <= ram_rdata;
        end else if (pop) begin
            head <= skid;
        end
        if (inflight && (stage_after_pop == 2'd1)) begin
            skid <= ram_rdata;
        end
    end

    a_stage_bound: assert property (@(posedge clk) disable iff (reset) (stage_cnt <= 2'd2));

endmodule

// File: tb/tb_fifo_ram_ctrl.sv
// tb/tb_fifo_ram_ctrl.sv - directed and scoreboard bench for fifo_ram_ctrl
module tb_fifo_ram_ctrl;

    localparam int SIZE  = 8;
    localparam int WIDTH = 16;
    localparam int AFULL = 6;

    logic             clk = 1'b0;
    logic             reset;
`ifdef FIFO_RAM_CTRL_FLUSH_EN
    logic             flush;
`endif
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_data;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_data;
    logic [4:0]       level;
    logic             almost_full;
    logic             ram_wen;
    logic [2:0]       ram_waddr;
    logic [WIDTH-1:0] ram_wdata;
    logic             ram_ren;
    logic [2:0]       ram_raddr;
    logic [WIDTH-1:0] ram_rdata;

    logic [WIDTH-1:0] mem [SIZE];

    int pass_cnt = 0;
    int total_cnt = 0;

    always #5 clk = ~clk;

    fifo_ram_ctrl #(.SIZE(SIZE), .WIDTH(WIDTH), .AFULL(AFULL)) dut (
        .clk(clk),
        .reset(reset),
`ifdef FIFO_RAM_CTRL_FLUSH_EN
        .flush(flush),
`endif
        .in_valid(in_valid),
        .in_ready(in_ready),
        .in_data(in_data),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_data(out_data),
        .level(level),
        .almost_full(almost_full),
        .ram_wen(ram_wen),
        .ram_waddr(ram_waddr),
        .ram_wdata(ram_wdata),
        .ram_ren(ram_ren),
        .ram_raddr(ram_raddr),
        .ram_rdata(ram_rdata)
    );

    // Registered RAM: write on edge, read data valid the cycle after ram_ren.
    always @(posedge clk) begin
        if (ram_wen) mem[ram_waddr] <= ram_wdata;
        if (ram_ren) ram_rdata <= mem[ram_raddr];
    end

    typedef struct {
        logic        iv;
        logic [15:0] d;
        logic        ordy;
        logic        ov;
        logic [15:0] od;
        int          lvl;
        logic        ir;
        logic        wen;
        int          waddr;
        logic        ren;
    } vec_t;

    vec_t vecs [11];

    task automatic check(input string name, input int act, input int exp);
        total_cnt++;
        if (act == exp) pass_cnt++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    endtask

    task automatic step(input logic iv, input logic [15:0] d, input logic ordy);
        @(posedge clk);
        #1;
        in_valid  = iv;
        in_data   = d;
        out_ready = ordy;
        @(negedge clk);
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1;
        reset     = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        @(posedge clk);
        #1;
        reset = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        int pushed, popped, bubbles, lvl_err, acc, lat, cycles, under;
        logic [15:0] sb [$];

        reset = 1'b1; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
`ifdef FIFO_RAM_CTRL_FLUSH_EN
        flush = 1'b0;
`endif
        vecs[0]  = '{1, 16'h11, 0, 0, 16'h00, 0, 1, 1, 0, 0};
        vecs[1]  = '{0, 16'h00, 0, 0, 16'h00, 1, 1, 0, 0, 1};
        vecs[2]  = '{0, 16'h00, 0, 0, 16'h00, 1, 1, 0, 0, 0};
        vecs[3]  = '{0, 16'h00, 0, 1, 16'h11, 1, 1, 0, 0, 0};
        vecs[4]  = '{0, 16'h00, 1, 1, 16'h11, 1, 1, 0, 0, 0};
        vecs[5]  = '{1, 16'h21, 1, 0, 16'h00, 0, 1, 1, 1, 0};
        vecs[6]  = '{1, 16'h22, 1, 0, 16'h00, 1, 1, 1, 2, 1};
        vecs[7]  = '{0, 16'h00, 1, 0, 16'h00, 2, 1, 0, 0, 1};
        vecs[8]  = '{0, 16'h00, 1, 1, 16'h21, 2, 1, 0, 0, 0};
        vecs[9]  = '{0, 16'h00, 1, 1, 16'h22, 1, 1, 0, 0, 0};
        vecs[10] = '{0, 16'h00, 1, 0, 16'h00, 0, 1, 0, 0, 0};

        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        check("reset_out_valid", int'(out_valid), 0);
        check("reset_level", int'(level), 0);
        check("reset_almost_full", int'(almost_full), 0);
        check("reset_in_ready", int'(in_ready), 1);
        check("reset_ram_ren", int'(ram_ren), 0);

        for (int i = 0; i < 11; i++) begin
            step(vecs[i].iv, vecs[i].d, vecs[i].ordy);
            check($sformatf("vec%0d_out_valid", i), int'(out_valid), int'(vecs[i].ov));
            if (vecs[i].ov) check($sformatf("vec%0d_out_data", i), int'(out_data), int'(vecs[i].od));
            check($sformatf("vec%0d_level", i), int'(level), vecs[i].lvl);
            check($sformatf("vec%0d_in_ready", i), int'(in_ready), int'(vecs[i].ir));
            check($sformatf("vec%0d_almost_full", i), int'(almost_full), 0);
            check($sformatf("vec%0d_ram_wen", i), int'(ram_wen), int'(vecs[i].wen));
            if (vecs[i].wen) check($sformatf("vec%0d_ram_waddr", i), int'(ram_waddr), vecs[i].waddr);
            check($sformatf("vec%0d_ram_ren", i), int'(ram_ren), int'(vecs[i].ren));
        end

        // Continuous streaming 0..99
        pushed = 0; popped = 0; bubbles = 0; lvl_err = 0;
        for (int c = 0; c < 400 && popped < 100; c++) begin
            step(pushed < 100, 16'(pushed), 1'b1);
            if (pushed >= 10 && pushed < 90 && level != 5'd3) lvl_err++;
            if (popped > 0 && popped < 100 && !out_valid) bubbles++;
            if (out_valid) begin
                check("stream_data", int'(out_data), popped);
                popped++;
            end
            if (in_valid && in_ready) pushed++;
        end
        check("stream_count", popped, 100);
        check("stream_bubbles", bubbles, 0);
        check("stream_level_steady", lvl_err, 0);

        // Fill until full with no consumer
        do_reset();
        acc = 0;
        for (int c = 0; c < 40; c++) begin
            step(1'b1, 16'(16'h100 + acc), 1'b0);
            check("fill_level", int'(level), acc);
            check("fill_almost_full", int'(almost_full), int'(acc >= AFULL));
            if (!in_ready) break;
            acc++;
        end
        check("fill_accepted", acc, SIZE + 2);
        check("fill_level_full", int'(level), SIZE + 2);
        check("fill_in_ready", int'(in_ready), 0);
        step(1'b0, 16'h0, 1'b1);
        check("fill_first_out", int'(out_data), 16'h100);
        step(1'b0, 16'h0, 1'b0);
        check("fill_in_ready_after_pop", int'(in_ready), 1);
        check("fill_level_after_pop", int'(level), SIZE + 1);
        popped = 1;
        for (int c = 0; c < 40 && popped < SIZE + 2; c++) begin
            step(1'b0, 16'h0, 1'b1);
            if (out_valid) begin
                check("drain_data", int'(out_data), 16'h100 + popped);
                popped++;
            end
        end
        check("drain_count", popped, SIZE + 2);
        step(1'b0, 16'h0, 1'b0);
        check("drain_level", int'(level), 0);
        check("drain_almost_full", int'(almost_full), 0);

        // Random handshakes against a scoreboard
        do_reset();
        pushed = 0; popped = 0; lvl_err = 0; under = 0; cycles = 0;
        while (popped < 2000 && cycles < 20000) begin
            step((pushed < 2000) && ($urandom_range(1) == 1), 16'($urandom), $urandom_range(1) == 1);
            cycles++;
            if (int'(level) != sb.size() || level > 5'd10) lvl_err++;
            if (out_valid && out_ready) begin
                if (sb.size() == 0) under++;
                else begin
                    check("rand_data", int'(out_data), int'(sb.pop_front()));
                    popped++;
                end
            end
            if (in_valid && in_ready) begin
                sb.push_back(in_data);
                pushed++;
            end
        end
        check("rand_count", popped, 2000);
        check("rand_level", lvl_err, 0);
        check("rand_underflow", under, 0);

        // Reset with words in RAM, stage and an outstanding read
        do_reset();
        step(1'b1, 16'h31, 1'b0);
        step(1'b1, 16'h32, 1'b0);
        step(1'b1, 16'h33, 1'b0);
        @(posedge clk);
        #1 reset = 1'b1; in_valid = 1'b0;
        @(negedge clk);
        @(posedge clk);
        #1 reset = 1'b0; in_valid = 1'b1; in_data = 16'hAB;
        @(negedge clk);
        check("midrst_out_valid", int'(out_valid), 0);
        check("midrst_level", int'(level), 0);
        check("midrst_in_ready", int'(in_ready), 1);
        check("midrst_waddr", int'(ram_waddr), 0);
        lat = 0;
        for (int k = 1; k <= 10; k++) begin
            step(1'b0, 16'h0, 1'b1);
            if (out_valid) begin
                lat = k;
                check("midrst_first_out", int'(out_data), 16'hAB);
                break;
            end
        end
        check("midrst_latency", lat, 3);

`ifdef FIFO_RAM_CTRL_FLUSH_EN
        do_reset();
        for (int i = 0; i < 6; i++) step(1'b1, 16'(16'h41 + i), 1'b0);
        step(1'b0, 16'h0, 1'b0);
        check("flush_pre_level", int'(level), 6);
        @(posedge clk);
        #1 flush = 1'b1; out_ready = 1'b1; in_valid = 1'b1; in_data = 16'hEE;
        @(negedge clk);
        check("flush_in_ready", int'(in_ready), 0);
        @(posedge clk);
        #1 flush = 1'b0; out_ready = 1'b0; in_valid = 1'b0;
        @(negedge clk);
        check("flush_level", int'(level), 0);
        check("flush_out_valid", int'(out_valid), 0);
        step(1'b1, 16'h5A, 1'b0);
        lat = 0;
        for (int k = 1; k <= 10; k++) begin
            step(1'b0, 16'h0, 1'b1);
            if (out_valid) begin
                lat = k;
                check("flush_next_out", int'(out_data), 16'h5A);
                break;
            end
        end
        check("flush_latency", lat, 3);
`endif

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
